// File: rtl/pll_dyn_cfg_if.sv
// Ratio-set handshake between a host and pll_dyn_cfg.
// Channel k of cfg_odiv sits at bits [10k+9:10k].
interface pll_dyn_cfg_if #(
  parameter int NUM_OUT = 1
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [9:0]            cfg_idiv;
  logic [9:0]            cfg_fdiv;
  logic [10*NUM_OUT-1:0] cfg_odiv;
  logic                  cfg_err;

  modport master (
    output cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/pll_dyn_cfg.sv
// Dynamic ratio reconfiguration and lock supervision for one GTP_PLL_E3 instance.
// Lock is synchronised, qualified over a stability window, retried on timeout and re-acquired after loss.
module pll_dyn_cfg #(
  parameter int NUM_OUT          = 1,
  parameter int DEF_IDIV         = 2,
  parameter int DEF_FDIV         = 24,
  parameter int DEF_ODIV         = 150,
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_STABLE_CYC  = 64,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 3,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pll_dyn_cfg_if.slave           cfg,
  input  logic                   pll_lock_i,
  output logic                   pll_rst_o,
  output logic                   rstodiv_o,
  output logic [9:0]             dyn_idiv_o,
  output logic [9:0]             dyn_fdiv_o,
  output logic [10*NUM_OUT-1:0]  dyn_odiv_o,
  output logic                   locked_o,
  output logic                   busy_o,
  output logic                   fail_o,
  output logic [RW-1:0]          retry_cnt_o,
  output logic [7:0]             lol_cnt_o
);
  localparam int HW = $clog2(RST_HOLD_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_RST, S_WAIT, S_LOCKED, S_FAIL} state_e;
  state_e state_q, state_d;

  logic                  lock_meta_q, lock_s_q;
  logic [HW-1:0]         hold_q, hold_d;
  logic [SW-1:0]         stable_q, stable_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [7:0]            lol_q, lol_d;
  logic [9:0]            idiv_q, idiv_d, fdiv_q, fdiv_d;
  logic [10*NUM_OUT-1:0] odiv_q, odiv_d;
  logic pll_rst_q, pll_rst_d, rstodiv_q, rstodiv_d, locked_q, locked_d;
  logic busy_q, busy_d, fail_q, fail_d, ready_q, ready_d, err_q, err_d;

  logic accept, odiv_zero, cfg_zero, load, stable_hit, timeout_hit, retry_left, lol;

  // cfg_ready is registered, so accept can only occur in LOCKED or FAIL.
  assign accept      = cfg.cfg_valid & ready_q;
  assign cfg_zero    = (cfg.cfg_idiv == 10'd0) | (cfg.cfg_fdiv == 10'd0) | odiv_zero;
  assign load        = accept & ~cfg_zero;
  assign stable_hit  = (state_q == S_WAIT) & lock_s_q & (stable_q == SW'(LOCK_STABLE_CYC - 1));
  assign timeout_hit = (state_q == S_WAIT) & (tmo_q == TW'(LOCK_TIMEOUT_CYC - 1));
  assign retry_left  = retry_q < RW'(MAX_RETRY);
  assign lol         = (state_q == S_LOCKED) & ~lock_s_q & ~load;

  always_comb begin
    odiv_zero = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (cfg.cfg_odiv[10*k +: 10] == 10'd0) odiv_zero = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // A valid handshake overrides everything, including a simultaneous loss of lock.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = S_RST;
    end else begin
      case (state_q)
        S_RST:    if (hold_q == HW'(RST_HOLD_CYC - 1)) state_d = S_WAIT;
        S_WAIT: begin
          if (stable_hit)       state_d = S_LOCKED;
          else if (timeout_hit) state_d = retry_left ? S_RST : S_FAIL;
        end
        S_LOCKED: if (!lock_s_q) state_d = S_RST;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    pll_rst_d = (state_d == S_RST) | (state_d == S_FAIL);
    rstodiv_d = (state_d != S_LOCKED);
    locked_d  = (state_d == S_LOCKED);
    busy_d    = (state_d == S_RST) | (state_d == S_WAIT);
    fail_d    = (state_d == S_FAIL);
    ready_d   = (state_d == S_LOCKED) | (state_d == S_FAIL);
    err_d     = accept & cfg_zero;
  end

  always_comb begin
    hold_d   = '0;
    stable_d = '0;
    tmo_d    = '0;
    retry_d  = retry_q;
    lol_d    = lol_q;
    idiv_d   = idiv_q;
    fdiv_d   = fdiv_q;
    odiv_d   = odiv_q;
    if (state_q == S_RST && state_d == S_RST)              hold_d   = hold_q + HW'(1);
    if (state_q == S_WAIT && state_d == S_WAIT)            tmo_d    = tmo_q + TW'(1);
    if (state_q == S_WAIT && state_d == S_WAIT && lock_s_q) stable_d = stable_q + SW'(1);
    if (load || lol || state_d == S_LOCKED)                retry_d  = '0;
    else if (timeout_hit && !stable_hit && retry_left)     retry_d  = retry_q + RW'(1);
    if (lol && lol_q != 8'hFF)                             lol_d    = lol_q + 8'd1;
    if (load) begin
      idiv_d = cfg.cfg_idiv;
      fdiv_d = cfg.cfg_fdiv;
      odiv_d = cfg.cfg_odiv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      hold_q      <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      lol_q       <= '0;
      idiv_q      <= 10'(DEF_IDIV);
      fdiv_q      <= 10'(DEF_FDIV);
      odiv_q      <= {NUM_OUT{10'(DEF_ODIV)}};
      pll_rst_q   <= 1'b1;
      rstodiv_q   <= 1'b1;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      fail_q      <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock_i;
      lock_s_q    <= lock_meta_q;
      hold_q      <= hold_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      lol_q       <= lol_d;
      idiv_q      <= idiv_d;
      fdiv_q      <= fdiv_d;
      odiv_q      <= odiv_d;
      pll_rst_q   <= pll_rst_d;
      rstodiv_q   <= rstodiv_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      fail_q      <= fail_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign pll_rst_o     = pll_rst_q;
  assign rstodiv_o     = rstodiv_q;
  assign dyn_idiv_o    = idiv_q;
  assign dyn_fdiv_o    = fdiv_q;
  assign dyn_odiv_o    = odiv_q;
  assign locked_o      = locked_q;
  assign busy_o        = busy_q;
  assign fail_o        = fail_q;
  assign retry_cnt_o   = retry_q;
  assign lol_cnt_o     = lol_q;
endmodule

// File: tb/tb_pll_dyn_cfg.sv
// Directed bench for pll_dyn_cfg: a phase/age model is compared against every output each cycle,
// and literal expectations pin the key cycles (lock latency, loss of lock, retries, handshakes).
module tb_pll_dyn_cfg;
  localparam int NOUT = 2, HOLD = 16, STAB = 64, TMO = 200, MAXR = 3;
  localparam int P_RST = 0, P_WAIT = 1, P_LOCK = 2, P_FAIL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pll_lock = 1'b0;
  logic pll_rst, rstodiv, locked, busy, fail;
  logic [9:0] dyn_idiv, dyn_fdiv;
  logic [10*NOUT-1:0] dyn_odiv;
  logic [1:0] retry_cnt;
  logic [7:0] lol_cnt;
  int n_chk = 0;
  int n_pass = 0;
  int cyc;
  int e;
  int t;

  pll_dyn_cfg_if #(.NUM_OUT(NOUT)) cif ();

  pll_dyn_cfg #(
    .NUM_OUT(NOUT), .DEF_IDIV(2), .DEF_FDIV(24), .DEF_ODIV(150),
    .RST_HOLD_CYC(HOLD), .LOCK_STABLE_CYC(STAB), .LOCK_TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cif), .pll_lock_i(pll_lock),
    .pll_rst_o(pll_rst), .rstodiv_o(rstodiv), .dyn_idiv_o(dyn_idiv), .dyn_fdiv_o(dyn_fdiv),
    .dyn_odiv_o(dyn_odiv), .locked_o(locked), .busy_o(busy), .fail_o(fail),
    .retry_cnt_o(retry_cnt), .lol_cnt_o(lol_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: which phase we are in, how long we have been there, and the current run of good lock samples.
  typedef struct {
    int phase, age, run, retry, lol;
    logic [9:0] idiv, fdiv;
    logic [10*NOUT-1:0] odiv;
    bit err, s1, s2;
  } m_t;
  m_t m;

  function automatic m_t m_reset();
    m_t r;
    r.phase = P_RST; r.age = 0; r.run = 0; r.retry = 0; r.lol = 0;
    r.idiv = 10'd2; r.fdiv = 10'd24; r.odiv = {10'd150, 10'd150};
    r.err = 0; r.s1 = 0; r.s2 = 0;
    return r;
  endfunction

  function automatic m_t step(input m_t s, input logic raw, input logic vld,
                              input logic [9:0] ci, input logic [9:0] cf, input logic [10*NOUT-1:0] co);
    m_t n = s;
    bit ls, acc, bad;
    ls = s.s2; n.s2 = s.s1; n.s1 = raw;
    acc = (s.phase == P_LOCK || s.phase == P_FAIL) && vld;
    bad = (ci == 0) || (cf == 0);
    for (int k = 0; k < NOUT; k++) if (co[10*k +: 10] == 0) bad = 1;
    n.err = acc && bad;
    if (acc && !bad) begin
      n.idiv = ci; n.fdiv = cf; n.odiv = co; n.retry = 0; n.phase = P_RST; n.age = 0;
    end else begin
      case (s.phase)
        P_RST: begin
          n.age = s.age + 1;
          if (n.age == HOLD) begin n.phase = P_WAIT; n.age = 0; n.run = 0; end
        end
        P_WAIT: begin
          n.age = s.age + 1;
          n.run = ls ? s.run + 1 : 0;
          if (n.run == STAB) begin
            n.phase = P_LOCK; n.retry = 0;
          end else if (n.age == TMO) begin
            if (s.retry < MAXR) begin n.retry = s.retry + 1; n.phase = P_RST; n.age = 0; end
            else n.phase = P_FAIL;
          end
        end
        P_LOCK: if (!ls) begin
          if (s.lol < 255) n.lol = s.lol + 1;
          n.retry = 0; n.phase = P_RST; n.age = 0;
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [63:0] model_outs(input m_t s);
    logic r, w, l, f;
    r = (s.phase == P_RST); w = (s.phase == P_WAIT); l = (s.phase == P_LOCK); f = (s.phase == P_FAIL);
    return {7'd0, r | f, !l, l, r | w, f, l | f, s.err, 2'(s.retry), 8'(s.lol), s.idiv, s.fdiv, s.odiv};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_reset();
    else        m <= step(m, pll_lock, cif.cfg_valid, cif.cfg_idiv, cif.cfg_fdiv, cif.cfg_odiv);
  end

  logic [63:0] dut_vec;
  assign dut_vec = {7'd0, pll_rst, rstodiv, locked, busy, fail, cif.cfg_ready, cif.cfg_err,
                    retry_cnt, lol_cnt, dyn_idiv, dyn_fdiv, dyn_odiv};

  always @(negedge clk) chk($sformatf("model_cyc%0d", cyc), dut_vec, model_outs(m));

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic offer(input logic [9:0] i, input logic [9:0] f, input logic [9:0] o1, input logic [9:0] o0);
    cif.cfg_valid = 1'b1; cif.cfg_idiv = i; cif.cfg_fdiv = f; cif.cfg_odiv = {o1, o0};
  endtask

  initial begin
    cif.cfg_valid = 1'b0; cif.cfg_idiv = '0; cif.cfg_fdiv = '0; cif.cfg_odiv = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pll_rst", pll_rst, 1);   chk("rst_rstodiv", rstodiv, 1);  chk("rst_busy", busy, 1);
    chk("rst_locked", locked, 0);     chk("rst_fail", fail, 0);        chk("rst_ready", cif.cfg_ready, 0);
    chk("rst_err", cif.cfg_err, 0);   chk("rst_retry", retry_cnt, 0);  chk("rst_lol", lol_cnt, 0);
    chk("rst_ratios", {dyn_idiv, dyn_fdiv, dyn_odiv}, {10'd2, 10'd24, 10'd150, 10'd150});
    #2 rst_n = 1'b1;

    // default bring-up: lock at cycle 30, qualified at 96
    at_cyc(15); chk("hold_pll_rst_c15", pll_rst, 1);
    at_cyc(16); chk("hold_pll_rst_c16", pll_rst, 0); chk("wait_rstodiv_c16", rstodiv, 1);
    at_cyc(30); pll_lock = 1'b1;
    at_cyc(95); chk("locked_c95", locked, 0); chk("rstodiv_c95", rstodiv, 1);
    at_cyc(96); chk("locked_c96", locked, 1); chk("rstodiv_c96", rstodiv, 0);
    chk("ready_c96", cif.cfg_ready, 1); chk("busy_c96", busy, 0);
    chk("ratios_c96", {dyn_idiv, dyn_fdiv, dyn_odiv}, {10'd2, 10'd24, 10'd150, 10'd150});

    // loss of lock and automatic relock
    at_cyc(110); pll_lock = 1'b0;
    at_cyc(112); chk("lol_locked_c112", locked, 1);
    at_cyc(113); chk("lol_locked_c113", locked, 0); chk("lol_pll_rst_c113", pll_rst, 1);
    chk("lol_cnt_1", lol_cnt, 1);
    at_cyc(115); pll_lock = 1'b1;
    at_cyc(192); chk("relock_c192", locked, 0);
    at_cyc(193); chk("relock_c193", locked, 1); chk("relock_idiv", dyn_idiv, 2);

    // one-cycle glitch at stable count 40 restarts qualification
    at_cyc(200); pll_lock = 1'b0;
    at_cyc(219); chk("glitch_wait_c219", pll_rst, 0); chk("lol_cnt_2", lol_cnt, 2); pll_lock = 1'b1;
    at_cyc(260); pll_lock = 1'b0;
    at_cyc(261); pll_lock = 1'b1;
    at_cyc(326); chk("glitch_locked_c326", locked, 0);
    at_cyc(327); chk("glitch_locked_c327", locked, 1); chk("glitch_retry", retry_cnt, 0);

    // zero ratios rejected (feedback, then output channel 1)
    at_cyc(340); offer(10'd5, 10'd0, 10'd7, 10'd9);
    at_cyc(341); cif.cfg_valid = 1'b0;
    chk("err_fdiv0", cif.cfg_err, 1); chk("err_locked", locked, 1); chk("err_fdiv_kept", dyn_fdiv, 24);
    at_cyc(342); chk("err_pulse_end", cif.cfg_err, 0);
    at_cyc(345); offer(10'd5, 10'd30, 10'd0, 10'd10);
    at_cyc(346); cif.cfg_valid = 1'b0;
    chk("err_odiv1", cif.cfg_err, 1); chk("err_odiv_kept", dyn_odiv, {10'd150, 10'd150});

    // valid handshake applies new ratios and relocks; offers while busy are ignored
    at_cyc(350); offer(10'd1, 10'd30, 10'd12, 10'd10);
    at_cyc(351); offer(10'd3, 10'd3, 10'd3, 10'd3);
    chk("cfg_pll_rst", pll_rst, 1); chk("cfg_locked", locked, 0); chk("cfg_busy", busy, 1);
    chk("cfg_ratios", {dyn_idiv, dyn_fdiv, dyn_odiv}, {10'd1, 10'd30, 10'd12, 10'd10});
    at_cyc(360); cif.cfg_valid = 1'b0; chk("busy_offer_ignored", dyn_idiv, 1);
    at_cyc(431); chk("cfg_relock_c431", locked, 1);

    // handshake in the same cycle lock_s falls
    at_cyc(440); pll_lock = 1'b0;
    at_cyc(442); chk("simul_ready", cif.cfg_ready, 1); offer(10'd4, 10'd40, 10'd21, 10'd20);
    at_cyc(443); cif.cfg_valid = 1'b0; pll_lock = 1'b1;
    chk("simul_lol_kept", lol_cnt, 2); chk("simul_pll_rst", pll_rst, 1);
    chk("simul_ratios", {dyn_idiv, dyn_fdiv, dyn_odiv}, {10'd4, 10'd40, 10'd21, 10'd20});
    at_cyc(523); chk("simul_relock_c523", locked, 1);

    // 300 loss-of-lock events saturate the counter at 255
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      repeat (2) @(negedge clk);
      pll_lock = 1'b1;
      repeat (3) @(negedge clk);
      t = 0;
      while (!locked && t < 200) begin @(negedge clk); t++; end
      chk($sformatf("relock_budget_%0d", i), locked, 1);
    end
    chk("lol_saturated", lol_cnt, 255);

    // lock never returns: four attempts, then FAIL
    e = cyc + 3; pll_lock = 1'b0;
    at_cyc(e + 215); chk("try1_retry", retry_cnt, 0); chk("try1_busy", busy, 1);
    at_cyc(e + 216); chk("try2_retry", retry_cnt, 1); chk("try2_pll_rst", pll_rst, 1);
    at_cyc(e + 863); chk("fail_pre", fail, 0);
    at_cyc(e + 864); chk("fail_set", fail, 1); chk("fail_ready", cif.cfg_ready, 1);
    chk("fail_pll_rst", pll_rst, 1); chk("fail_busy", busy, 0); chk("fail_retry", retry_cnt, 3);

    // leaving FAIL: zero ratio rejected, then a valid set restarts
    at_cyc(e + 870); offer(10'd0, 10'd9, 10'd9, 10'd9);
    at_cyc(e + 871); cif.cfg_valid = 1'b0; chk("fail_err", cif.cfg_err, 1); chk("fail_stays", fail, 1);
    at_cyc(e + 875); offer(10'd3, 10'd33, 10'd6, 10'd5); pll_lock = 1'b1;
    at_cyc(e + 876); cif.cfg_valid = 1'b0;
    chk("unfail_fail", fail, 0); chk("unfail_retry", retry_cnt, 0); chk("unfail_idiv", dyn_idiv, 3);
    at_cyc(e + 960); chk("unfail_locked", locked, 1);

    // asynchronous reset mid-run restores defaults immediately
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pll_rst", pll_rst, 1); chk("arst_locked", locked, 0); chk("arst_lol", lol_cnt, 0);
    chk("arst_ratios", {dyn_idiv, dyn_fdiv, dyn_odiv}, {10'd2, 10'd24, 10'd150, 10'd150});
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    at_cyc(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
